gpio_ctrl: RTL and testbench

Parametrised memory-mapped GPIO peripheral for the RockWave core: IN_WIDTH input pins with 2-flop synchronisation, tick-based debounce and per-bit edge detection, plus OUT_WIDTH output latches. It connects to the core data-bus register port. It generalises the fixed 8-bit loopback GPIO with configurable widths, debounce, edge status and a level interrupt to the core.

---
 rtl/gpio_ctrl.sv | 108 ++++++++++
 tb/tb_gpio_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: synchronised, tick-debounced inputs with per-bit edge
// status and a level interrupt, plus a bank of output latches.
module gpio_ctrl #(
    parameter int IN_WIDTH        = 32,
    parameter int OUT_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           addr,
    input  logic [31:0]          wdata,
    input  logic                 we,
    input  logic                 re,
    output logic [31:0]          rdata,
    input  logic [IN_WIDTH-1:0]  gpio_pin_in,
    output logic [OUT_WIDTH-1:0] gpio_pin_out,
    output logic                 irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] REG_GPO       = 3'd0;
    localparam logic [2:0] REG_GPI       = 3'd1;
    localparam logic [2:0] REG_EDGE_STAT = 3'd2;
    localparam logic [2:0] REG_IRQ_EN    = 3'd3;
    localparam logic [2:0] REG_EDGE_POL  = 3'd4;
    localparam logic [2:0] REG_EDGE_BOTH = 3'd5;

    // Bus handshake: we and re are single-cycle strobes sampled on the rising
    // edge; rdata carries the addressed register the cycle after re, else 0.
    logic [OUT_WIDTH-1:0] gpo;
    logic [IN_WIDTH-1:0]  sync1, sync2, samp, deb, deb_d;
    logic [IN_WIDTH-1:0]  edge_status, irq_en, edge_pol, edge_both;
    logic [CNT_W-1:0]     cnt;

    logic [2:0]          sel;
    logic                tick;
    logic [IN_WIDTH-1:0] rise, fall, ev, clr, wlow;
    logic [31:0]         rd_mux;
    logic                unused_bits;

    assign unused_bits  = ^{addr[1:0], wdata};
    assign gpio_pin_out = gpo;

    always_comb begin
        sel  = addr[4:2];
        tick = (cnt == CNT_LAST);
        wlow = wdata[IN_WIDTH-1:0];
        rise = deb & ~deb_d;
        fall = ~deb & deb_d;
        ev   = (edge_both & (rise | fall)) | (~edge_both & ((edge_pol & rise) | (~edge_pol & fall)));
        clr  = (we && sel == REG_EDGE_STAT) ? wlow : '0;
        case (sel)
            REG_GPO:       rd_mux = 32'(gpo);
            REG_GPI:       rd_mux = 32'(deb);
            REG_EDGE_STAT: rd_mux = 32'(edge_status);
            REG_IRQ_EN:    rd_mux = 32'(irq_en);
            REG_EDGE_POL:  rd_mux = 32'(edge_pol);
            REG_EDGE_BOTH: rd_mux = 32'(edge_both);
            default:       rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gpo         <= '0;
            sync1       <= '0;
            sync2       <= '0;
            samp        <= '0;
            deb         <= '0;
            deb_d       <= '0;
            edge_status <= '0;
            irq_en      <= '0;
            edge_pol    <= '0;
            edge_both   <= '0;
            cnt         <= '0;
            rdata       <= '0;
            irq         <= 1'b0;
        end else begin
            sync1 <= gpio_pin_in;
            sync2 <= sync1;
            cnt   <= tick ? '0 : cnt + 1'b1;
            // A level is accepted only once it has been seen on two consecutive ticks.
            if (tick) begin
                samp <= sync2;
                deb  <= (samp & sync2) | (deb & (samp ^ sync2));
            end
            deb_d <= deb;

            // Set wins over a simultaneous write-one-to-clear.
            edge_status <= (edge_status & ~clr) | ev;
            irq         <= |(edge_status & irq_en);
            rdata       <= re ? rd_mux : 32'd0;

            if (we) begin
                case (sel)
                    REG_GPO:       gpo       <= wdata[OUT_WIDTH-1:0];
                    REG_IRQ_EN:    irq_en    <= wlow;
                    REG_EDGE_POL:  edge_pol  <= wlow;
                    REG_EDGE_BOTH: edge_both <= wlow;
                    default:       ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: reads feed a scoreboard queue checked by a
// separate monitor; pin/irq levels are checked directly at the falling edge.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic [31:0] gpio_pin_in = '0;
    logic [7:0]  gpio_pin_out;
    logic        irq;

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    gpio_ctrl #(.IN_WIDTH(32), .OUT_WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .gpio_pin_in(gpio_pin_in), .gpio_pin_out(gpio_pin_out), .irq(irq)
    );

    always #5 clk = ~clk;

    // Monitor: rdata is valid just after the edge at which re was sampled high.
    initial begin
        forever begin
            @(posedge clk);
            if (re === 1'b1) begin
                #1;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_read: got 0x%08h, no expected entry", rdata);
                end else begin
                    logic [31:0] e;
                    string       nm;
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (rdata !== e) begin
                        n_errors++;
                        $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, rdata, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] pins);
        gpio_pin_in = pins;
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        addr  = {idx, 2'b00};
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx, input logic [31:0] e, input string nm);
        addr = {idx, 2'b00};
        exp_q.push_back(e);
        name_q.push_back(nm);
        re   = 1'b1;
        @(negedge clk);
        re   = 1'b0;
    endtask

    task automatic wait_deb0(input logic val, input string nm);
        for (int i = 0; i < 40 && dut.deb[0] !== val; i++) @(negedge clk);
        chk(nm, {31'd0, dut.deb[0]}, {31'd0, val});
    endtask

    initial begin
        // Reset with all pins high: everything reads zero until debounce accepts.
        cycles(1);
        do_reset(32'hFFFF_FFFF);
        rd(3'd0, 32'h0, "reset_gpo");
        rd(3'd1, 32'h0, "reset_gpi");
        rd(3'd2, 32'h0, "reset_edge_status");
        rd(3'd3, 32'h0, "reset_irq_en");
        rd(3'd4, 32'h0, "reset_edge_pol");
        rd(3'd5, 32'h0, "reset_edge_both");
        chk("reset_pin_out", {24'd0, gpio_pin_out}, 32'h0);
        chk("reset_irq", {31'd0, irq}, 32'h0);
        cycles(11);
        rd(3'd1, 32'hFFFF_FFFF, "gpi_after_reset");

        do_reset(32'h0);
        cycles(12);

        // GPO write keeps the low OUT_WIDTH bits only.
        wr(3'd0, 32'h1A5);
        chk("gpo_pin_out", {24'd0, gpio_pin_out}, 32'hA5);
        rd(3'd0, 32'h0000_00A5, "gpo_read");
        addr = 5'b00001;
        exp_q.push_back(32'hA5); name_q.push_back("gpo_read_low_addr_ignored");
        re = 1'b1; @(negedge clk); re = 1'b0;
        // Simultaneous write and read: read sees the old value.
        addr = 5'd0; wdata = 32'h3C; we = 1'b1; re = 1'b1;
        exp_q.push_back(32'hA5); name_q.push_back("rw_same_cycle_old");
        @(negedge clk); we = 1'b0; re = 1'b0;
        chk("rw_same_cycle_pin_out", {24'd0, gpio_pin_out}, 32'h3C);

        // Debounce: a 2-cycle glitch is rejected, a held level is accepted.
        gpio_pin_in = 32'h8; cycles(2); gpio_pin_in = 32'h0;
        cycles(14);
        rd(3'd1, 32'h0, "glitch_gpi");
        rd(3'd2, 32'h0, "glitch_edge_status");
        gpio_pin_in = 32'h8;
        cycles(12);
        rd(3'd1, 32'h8, "held_gpi");

        // Edge modes on bit 0: rising only, then both.
        wr(3'd4, 32'h1);
        gpio_pin_in = 32'h9;
        wait_deb0(1'b1, "rise_deb");
        cycles(2);
        rd(3'd2, 32'h1, "pol_rise_status");
        wr(3'd2, 32'h1);
        gpio_pin_in = 32'h8;
        wait_deb0(1'b0, "fall_deb");
        cycles(2);
        rd(3'd2, 32'h0, "pol_fall_ignored");
        wr(3'd5, 32'h1);
        gpio_pin_in = 32'h9;
        wait_deb0(1'b1, "both_rise_deb");
        cycles(2);
        wr(3'd2, 32'h1);
        gpio_pin_in = 32'h8;
        wait_deb0(1'b0, "both_fall_deb");
        cycles(2);
        rd(3'd2, 32'h1, "both_fall_status");
        wr(3'd2, 32'h1);
        rd(3'd2, 32'h0, "w1c_clears");

        // IRQ: asserts two cycles after deb changes; W1C drops it one cycle later.
        wr(3'd3, 32'h1);
        gpio_pin_in = 32'h9;
        wait_deb0(1'b1, "irq_deb");
        chk("irq_t0", {31'd0, irq}, 32'h0);
        cycles(1);
        chk("irq_t1", {31'd0, irq}, 32'h0);
        cycles(1);
        chk("irq_t2", {31'd0, irq}, 32'h1);
        wr(3'd2, 32'h1);
        chk("irq_after_w1c_edge", {31'd0, irq}, 32'h1);
        cycles(1);
        chk("irq_dropped", {31'd0, irq}, 32'h0);
        rd(3'd2, 32'h0, "status_after_w1c");

        // Set wins: clear of bit 0 in the very cycle a new bit-0 event lands.
        gpio_pin_in = 32'h8;
        wait_deb0(1'b0, "race_fall_deb");
        cycles(3);
        chk("race_irq_before", {31'd0, irq}, 32'h1);
        gpio_pin_in = 32'h9;
        wait_deb0(1'b1, "race_rise_deb");
        wr(3'd2, 32'h1);
        chk("race_irq_a", {31'd0, irq}, 32'h1);
        cycles(1);
        chk("race_irq_b", {31'd0, irq}, 32'h1);
        rd(3'd2, 32'h1, "race_status_kept");

        // Reserved index: writes ignored, reads zero.
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, 32'h0, "reserved_read");
        rd(3'd0, 32'h3C, "gpo_untouched");
        chk("reserved_pin_out", {24'd0, gpio_pin_out}, 32'h3C);

        cycles(3);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
